regfile_wb_ctrl: RTL and testbench

- Write-side controller for the 32x32 integer register file. Arbitrates the single-cycle ALU result stream and the variable-latency load-response stream onto the file's one write port (addr/data/wren).
- Keeps a pending-load scoreboard so issue can detect RAW/WAW hazards against in-flight loads.
- Sits between execute/LSU and the register file, alongside issue.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/wb_load_fifo.sv | 53 +++++
 rtl/regfile_wb_ctrl.sv | 117 +++++++++++
 tb/tb_regfile_wb_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register-file write side.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // One buffered load response: destination register plus the loaded value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Small synchronous FIFO buffering load responses until the write port is free.
// The head entry is visible combinationally so the arbiter can pop it directly.
module wb_load_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  wb_entry_t mem [DEPTH];

  // The extra pointer bit distinguishes full from empty when the indices match.
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;

  // Storage holds no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
  end

  // Pointer update; a reset discards whatever is still buffered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign head  = mem[rd_ptr[PTR_W-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // The producer must respect the ready signal derived from full.
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-side controller for the 32x32 register file: arbitrates ALU results
// (priority) and buffered load responses onto the single registered write port,
// and tracks registers with loads in flight for issue hazard detection.
// Optional macro WB_BYPASS_EN adds write-to-read forwarding outputs.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int XLEN       = regfile_pkg::XLEN,
  parameter int LBUF_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            ld_valid_i,
  output logic            ld_ready_o,
  input  logic [4:0]      ld_rd_i,
  input  logic [XLEN-1:0] ld_data_i,
  input  logic            issue_ld_i,
  input  logic [4:0]      issue_rd_i,
  output logic            issue_ok_o,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic            hazard_o,
`ifdef WB_BYPASS_EN
  output logic            rs1_fwd_o,
  output logic            rs2_fwd_o,
  output logic [XLEN-1:0] fwd_data_o,
`endif
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wren_o
);

  wb_entry_t             lbuf_in;
  wb_entry_t             lbuf_head;
  logic                  lbuf_full;
  logic                  lbuf_empty;
  logic                  lbuf_push;
  logic                  lbuf_pop;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;

  assign ld_ready_o = !lbuf_full && !rst_i;
  assign lbuf_push  = ld_valid_i && ld_ready_o;
  assign lbuf_pop   = !alu_valid_i && !lbuf_empty;
  assign lbuf_in    = '{rd: ld_rd_i, data: ld_data_i};

  wb_load_fifo #(
    .DEPTH(LBUF_DEPTH)
  ) u_lbuf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (lbuf_push),
    .push_data (lbuf_in),
    .pop       (lbuf_pop),
    .head      (lbuf_head),
    .full      (lbuf_full),
    .empty     (lbuf_empty)
  );

  // Registered write port: ALU wins, otherwise drain the load buffer head; x0 never writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_wren_o <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else if (alu_valid_i) begin
      rd_wren_o <= (alu_rd_i != '0);
      rd_addr_o <= alu_rd_i;
      rd_data_o <= alu_data_i;
    end else if (lbuf_pop) begin
      rd_wren_o <= (lbuf_head.rd != '0);
      rd_addr_o <= lbuf_head.rd;
      rd_data_o <= lbuf_head.data;
    end else begin
      rd_wren_o <= 1'b0;
    end
  end

  // Scoreboard update: clear on pop of the register's load, then set on issue so set wins.
  always_comb begin
    busy_next = busy;
    if (lbuf_pop && (lbuf_head.rd != '0)) begin
      busy_next[lbuf_head.rd] = 1'b0;
    end
    if (issue_ld_i && (issue_rd_i != '0)) begin
      busy_next[issue_rd_i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign hazard_o   = busy[rs1_addr_i] | busy[rs2_addr_i];
  assign issue_ok_o = !busy[issue_rd_i];

`ifdef WB_BYPASS_EN
  assign rs1_fwd_o  = rd_wren_o && (rd_addr_o == rs1_addr_i);
  assign rs2_fwd_o  = rd_wren_o && (rd_addr_o == rs2_addr_i);
  assign fwd_data_o = rd_data_o;
`endif

  // A new load may only target a busy register if its old load retires this very cycle.
  a_issue_not_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    (issue_ld_i && (issue_rd_i != '0) && busy[issue_rd_i]) |->
    (lbuf_pop && (lbuf_head.rd == issue_rd_i)));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed testbench for regfile_wb_ctrl (default build, no forwarding ports).
module tb_regfile_wb_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [4:0]  ld_rd_i;
  logic [31:0] ld_data_i;
  logic        issue_ld_i;
  logic [4:0]  issue_rd_i;
  logic        issue_ok_o;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        hazard_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_wren_o;

  int tests_run;
  int tests_failed;

  regfile_wb_ctrl #(
    .XLEN(32),
    .LBUF_DEPTH(2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alu_valid_i (alu_valid_i),
    .alu_rd_i    (alu_rd_i),
    .alu_data_i  (alu_data_i),
    .ld_valid_i  (ld_valid_i),
    .ld_ready_o  (ld_ready_o),
    .ld_rd_i     (ld_rd_i),
    .ld_data_i   (ld_data_i),
    .issue_ld_i  (issue_ld_i),
    .issue_rd_i  (issue_rd_i),
    .issue_ok_o  (issue_ok_o),
    .rs1_addr_i  (rs1_addr_i),
    .rs2_addr_i  (rs2_addr_i),
    .hazard_o    (hazard_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .rd_wren_o   (rd_wren_o)
  );

  // Free-running 10 ns clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive every stream input, then let combinational outputs settle.
  task automatic applyStimulus(input logic a_v, input logic [4:0] a_rd, input logic [31:0] a_d,
                               input logic l_v, input logic [4:0] l_rd, input logic [31:0] l_d,
                               input logic i_v, input logic [4:0] i_rd);
    alu_valid_i = a_v;
    alu_rd_i    = a_rd;
    alu_data_i  = a_d;
    ld_valid_i  = l_v;
    ld_rd_i     = l_rd;
    ld_data_i   = l_d;
    issue_ld_i  = i_v;
    issue_rd_i  = i_rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_i        = 1'b1;
    rs1_addr_i   = 5'd0;
    rs2_addr_i   = 5'd0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    tick();
    tick();
    checkOutput("rst_wren",  {31'd0, rd_wren_o},  32'd0);
    checkOutput("rst_addr",  {27'd0, rd_addr_o},  32'd0);
    checkOutput("rst_data",  rd_data_o,           32'd0);
    checkOutput("rst_ready", {31'd0, ld_ready_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    checkOutput("post_rst_ready", {31'd0, ld_ready_o}, 32'd1);
    checkOutput("post_rst_hazard", {31'd0, hazard_o}, 32'd0);

    // ALU only: one-cycle write the cycle after selection
    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alu_wren", {31'd0, rd_wren_o}, 32'd1);
    checkOutput("alu_addr", {27'd0, rd_addr_o}, 32'd5);
    checkOutput("alu_data", rd_data_o, 32'hDEADBEEF);
    tick();
    checkOutput("alu_wren_drop", {31'd0, rd_wren_o}, 32'd0);

    // Load flow with scoreboard
    rs1_addr_i = 5'd7;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7);
    checkOutput("ld_issue_ok_before", {31'd0, issue_ok_o}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 1, 5'd7, 32'h1234, 0, 5'd7);
    checkOutput("ld_hazard_set", {31'd0, hazard_o}, 32'd1);
    checkOutput("ld_issue_ok_busy", {31'd0, issue_ok_o}, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ld_no_write_yet", {31'd0, rd_wren_o}, 32'd0);
    checkOutput("ld_hazard_held", {31'd0, hazard_o}, 32'd1);
    tick();
    checkOutput("ld_wren", {31'd0, rd_wren_o}, 32'd1);
    checkOutput("ld_addr", {27'd0, rd_addr_o}, 32'd7);
    checkOutput("ld_data", rd_data_o, 32'h1234);
    checkOutput("ld_hazard_clear", {31'd0, hazard_o}, 32'd0);
    tick();
    checkOutput("ld_wren_drop", {31'd0, rd_wren_o}, 32'd0);
    rs1_addr_i = 5'd0;

    // Contention: ALU holds the port while two loads fill the buffer
    applyStimulus(1, 5'd10, 32'hA, 1, 5'd8, 32'h88, 0, 0);
    checkOutput("ct_ready0", {31'd0, ld_ready_o}, 32'd1);
    tick();
    applyStimulus(1, 5'd11, 32'hB, 1, 5'd9, 32'h99, 0, 0);
    checkOutput("ct_ready1", {31'd0, ld_ready_o}, 32'd1);
    checkOutput("ct_addr10", {27'd0, rd_addr_o}, 32'd10);
    tick();
    applyStimulus(1, 5'd12, 32'hC, 0, 0, 0, 0, 0);
    checkOutput("ct_full_ready", {31'd0, ld_ready_o}, 32'd0);
    checkOutput("ct_addr11", {27'd0, rd_addr_o}, 32'd11);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ct_addr12", {27'd0, rd_addr_o}, 32'd12);
    checkOutput("ct_data12", rd_data_o, 32'hC);
    checkOutput("ct_ready_popping", {31'd0, ld_ready_o}, 32'd0);
    tick();
    checkOutput("ct_wren8", {31'd0, rd_wren_o}, 32'd1);
    checkOutput("ct_addr8", {27'd0, rd_addr_o}, 32'd8);
    checkOutput("ct_data8", rd_data_o, 32'h88);
    checkOutput("ct_ready_after", {31'd0, ld_ready_o}, 32'd1);
    tick();
    checkOutput("ct_addr9", {27'd0, rd_addr_o}, 32'd9);
    checkOutput("ct_data9", rd_data_o, 32'h99);
    tick();
    checkOutput("ct_idle", {31'd0, rd_wren_o}, 32'd0);

    // x0 handling
    applyStimulus(1, 5'd0, 32'h1, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 5'd0, 32'h2, 1, 5'd0);
    checkOutput("x0_alu_wren", {31'd0, rd_wren_o}, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_hazard", {31'd0, hazard_o}, 32'd0);
    checkOutput("x0_issue_ok", {31'd0, issue_ok_o}, 32'd1);
    tick();
    checkOutput("x0_ld_wren", {31'd0, rd_wren_o}, 32'd0);

    // Same-cycle set and clear of x4: set wins
    rs1_addr_i = 5'd4;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd4);
    tick();
    applyStimulus(0, 0, 0, 1, 5'd4, 32'h44, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd4);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd4);
    checkOutput("sc_wren", {31'd0, rd_wren_o}, 32'd1);
    checkOutput("sc_addr", {27'd0, rd_addr_o}, 32'd4);
    checkOutput("sc_hazard", {31'd0, hazard_o}, 32'd1);
    checkOutput("sc_issue_ok", {31'd0, issue_ok_o}, 32'd0);
    applyStimulus(0, 0, 0, 1, 5'd4, 32'h45, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("sc_second_data", rd_data_o, 32'h45);
    checkOutput("sc_hazard_clear", {31'd0, hazard_o}, 32'd0);

    // Reset with two buffered loads and two busy registers
    rs1_addr_i = 5'd20;
    rs2_addr_i = 5'd21;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd20);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd21);
    tick();
    applyStimulus(1, 5'd13, 32'h13, 1, 5'd20, 32'h20, 0, 0);
    checkOutput("mr_hazard", {31'd0, hazard_o}, 32'd1);
    tick();
    applyStimulus(1, 5'd14, 32'h14, 1, 5'd21, 32'h21, 0, 0);
    tick();
    applyStimulus(1, 5'd15, 32'h15, 0, 0, 0, 0, 0);
    checkOutput("mr_full", {31'd0, ld_ready_o}, 32'd0);
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("mr_rst_wren", {31'd0, rd_wren_o}, 32'd0);
    checkOutput("mr_rst_ready", {31'd0, ld_ready_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    checkOutput("mr_ready_after", {31'd0, ld_ready_o}, 32'd1);
    checkOutput("mr_hazard_after", {31'd0, hazard_o}, 32'd0);
    tick();
    checkOutput("mr_no_write1", {31'd0, rd_wren_o}, 32'd0);
    tick();
    checkOutput("mr_no_write2", {31'd0, rd_wren_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
